// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN feature-map pipeline.
//
// Purpose:
//   Holds the sample width, the conv2 output feature-map size (8x8), and the
//   derived pooled-map size (4x4). It also holds the per-pixel role
//   enumeration that the pooling top uses to steer its channel slices.
//   A small helper returns an index width that is never zero.
//
// Ports: none (package).
//
// Configuration macro used by the pooling slices: MAXPOOL2_RELU_EN.
package cnn_pkg;

  // Signed sample width on the conv2 -> pool path.
  localparam int CNN_DATA_BITS = 12;

  // conv2 output feature map dimensions.
  localparam int CONV2_WIDTH  = 8;
  localparam int CONV2_HEIGHT = 8;

  // 2x2 stride-2 pooling halves each dimension.
  localparam int POOL_WIDTH  = CONV2_WIDTH / 2;
  localparam int POOL_HEIGHT = CONV2_HEIGHT / 2;

  // What a valid pixel does inside a channel slice, decided from the
  // parity of its column and row:
  //   ROLE_HOLD - even column: load the pair register.
  //   ROLE_LINE - odd column, even row: write the pair max to the line buffer.
  //   ROLE_POOL - odd column, odd row: combine with the line buffer and emit.
  //   ROLE_IDLE - no valid pixel this cycle, so all state holds.
  typedef enum logic [1:0] {
    ROLE_IDLE = 2'd0,
    ROLE_HOLD = 2'd1,
    ROLE_LINE = 2'd2,
    ROLE_POOL = 2'd3
  } pixel_role_e;

  // Index width for a counter or memory of n entries. The result is at
  // least 1, so small configurations never produce zero-width vectors.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_relu2_if.sv
// Stream interface between conv2, the 2x2 max-pool block, and its consumer.
//
// Purpose:
//   Bundles the three-channel input sample stream and the pooled output
//   stream of maxpool_relu2.
//
// Signals:
//   valid_in               - one raster-order pixel per channel this cycle
//   conv2_out_1/2/3        - signed conv2 samples, channels 1-3
//   max_value_1/2/3        - signed pooled results, channels 1-3
//   valid_out              - max_value_* are valid this cycle
//   frame_done             - pulse with the last pooled output of a frame
//
// Modports:
//   master - the upstream/environment side. It drives the samples and
//            observes the results.
//   slave  - the pooling block. It consumes the samples and drives the
//            results.
interface maxpool_relu2_if
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = CNN_DATA_BITS
);

  logic                        valid_in;
  logic signed [DATA_BITS-1:0] conv2_out_1;
  logic signed [DATA_BITS-1:0] conv2_out_2;
  logic signed [DATA_BITS-1:0] conv2_out_3;

  logic signed [DATA_BITS-1:0] max_value_1;
  logic signed [DATA_BITS-1:0] max_value_2;
  logic signed [DATA_BITS-1:0] max_value_3;
  logic                        valid_out;
  logic                        frame_done;

  modport master (
    output valid_in,
    output conv2_out_1,
    output conv2_out_2,
    output conv2_out_3,
    input  max_value_1,
    input  max_value_2,
    input  max_value_3,
    input  valid_out,
    input  frame_done
  );

  modport slave (
    input  valid_in,
    input  conv2_out_1,
    input  conv2_out_2,
    input  conv2_out_3,
    output max_value_1,
    output max_value_2,
    output max_value_3,
    output valid_out,
    output frame_done
  );

endinterface

// File: rtl/pool2_channel.sv
// One channel of 2x2 stride-2 max pooling.
//
// Purpose:
//   Holds the datapath for a single channel: an optional ReLU clamp, the
//   horizontal pair register, a line buffer of WIDTH/2 pair maxima from the
//   even row, the signed comparators, and the registered pooled result.
//   The pixel counters live in the top, which tells this slice what to do
//   through the role and address inputs.
//
// Ports:
//   clk        - clock; state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   role       - action for this cycle's pixel (see cnn_pkg::pixel_role_e)
//   addr       - line buffer address, equal to column / 2
//   sample     - signed input sample for this channel
//   max_value  - registered pooled result; holds between results
//
// Configuration:
//   MAXPOOL2_RELU_EN - when defined, negative samples are clamped to zero
//                      before pooling.
module pool2_channel
  import cnn_pkg::*;
#(
  parameter int WIDTH     = CONV2_WIDTH,
  parameter int DATA_BITS = CNN_DATA_BITS,
  parameter int ADDR_W    = clog2_min1(WIDTH / 2)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  pixel_role_e                 role,
  input  logic [ADDR_W-1:0]           addr,
  input  logic signed [DATA_BITS-1:0] sample,
  output logic signed [DATA_BITS-1:0] max_value
);

  localparam int LINE_DEPTH = WIDTH / 2;

  logic signed [DATA_BITS-1:0] sample_act;
  logic signed [DATA_BITS-1:0] pair_reg;
  logic signed [DATA_BITS-1:0] pair_max;
  logic signed [DATA_BITS-1:0] line_rd;
  logic signed [DATA_BITS-1:0] pool_max;

  // Pair maxima of the even row, one per output column. This buffer is not
  // reset. Every entry is written in the even row before the odd row reads
  // it, so stale contents are never used.
  logic signed [DATA_BITS-1:0] line_buf [LINE_DEPTH];

  // Signed maximum. On a tie both operands are equal, so either one is fine.
  function automatic logic signed [DATA_BITS-1:0] smax(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Optional activation. The clamp happens before any comparison, so every
  // stored or emitted value is already non-negative when it is enabled.
  always_comb begin
    sample_act = sample;
`ifdef MAXPOOL2_RELU_EN
    if (sample[DATA_BITS-1]) begin
      sample_act = '0;
    end
`endif
  end

  // Horizontal and vertical reductions. These are evaluated every cycle and
  // only take effect through the role-qualified registers below.
  always_comb begin
    pair_max = smax(pair_reg, sample_act);
    line_rd  = line_buf[addr];
    pool_max = smax(line_rd, pair_max);
  end

  // Pair register and output register. Both are reset and both hold unless
  // their role is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_reg  <= '0;
      max_value <= '0;
    end else begin
      if (role == ROLE_HOLD) begin
        pair_reg <= sample_act;
      end
      if (role == ROLE_POOL) begin
        max_value <= pool_max;
      end
    end
  end

  // Line buffer write on odd columns of even rows.
  always_ff @(posedge clk) begin
    if (role == ROLE_LINE) begin
      line_buf[addr] <= pair_max;
    end
  end

endmodule

// File: rtl/maxpool_relu2.sv
// Three-channel 2x2 stride-2 max pooling with optional ReLU, after conv2.
//
// Purpose:
//   Takes a raster-order stream of WIDTH x HEIGHT pixels per channel and
//   emits WIDTH/2 x HEIGHT/2 pooled values per channel. The output appears
//   one cycle after the fourth contributing pixel. The column and row
//   counters and the valid/frame_done timing are shared. Each channel's
//   datapath is a pool2_channel instance, and all three run in lock-step.
//
// Ports:
//   clk    - clock; state changes on the rising edge
//   rst_n  - synchronous active-low reset; abandons any partial frame
//   bus    - maxpool_relu2_if.slave: valid_in, conv2_out_1..3 in;
//            max_value_1..3, valid_out, frame_done out
//
// Configuration:
//   MAXPOOL2_RELU_EN - when defined, negative samples are clamped to zero
//                      before pooling (handled in pool2_channel).
module maxpool_relu2
  import cnn_pkg::*;
#(
  parameter int WIDTH     = CONV2_WIDTH,
  parameter int HEIGHT    = CONV2_HEIGHT,
  parameter int DATA_BITS = CNN_DATA_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  maxpool_relu2_if.slave  bus
);

  localparam int COL_W  = clog2_min1(WIDTH);
  localparam int ROW_W  = clog2_min1(HEIGHT);
  localparam int ADDR_W = clog2_min1(WIDTH / 2);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_last;
  logic              row_last;
  logic [COL_W-1:0]  col_half;
  logic [ADDR_W-1:0] line_addr;
  pixel_role_e       role;
  logic              valid_out_r;
  logic              frame_done_r;

  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  assign col_half  = col >> 1;
  assign line_addr = col_half[ADDR_W-1:0];

  // Raster position of the pixel currently on the input. The counters move
  // only on valid pixels. When the last row wraps, the next valid pixel is
  // (0,0) of a new frame, with no gap required.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Decode what this pixel contributes. The low bit of each counter gives
  // its parity, which holds because WIDTH and HEIGHT are even.
  always_comb begin
    role = ROLE_IDLE;
    if (bus.valid_in) begin
      if (!col[0]) begin
        role = ROLE_HOLD;
      end else if (!row[0]) begin
        role = ROLE_LINE;
      end else begin
        role = ROLE_POOL;
      end
    end
  end

  // The channel slices register their result on the same edge, so valid_out
  // lines up with max_value_*. frame_done marks the bottom-right pooled
  // output only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      valid_out_r  <= (role == ROLE_POOL);
      frame_done_r <= (role == ROLE_POOL) && col_last && row_last;
    end
  end

  assign bus.valid_out  = valid_out_r;
  assign bus.frame_done = frame_done_r;

  pool2_channel #(
    .WIDTH     (WIDTH),
    .DATA_BITS (DATA_BITS),
    .ADDR_W    (ADDR_W)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .role      (role),
    .addr      (line_addr),
    .sample    (bus.conv2_out_1),
    .max_value (bus.max_value_1)
  );

  pool2_channel #(
    .WIDTH     (WIDTH),
    .DATA_BITS (DATA_BITS),
    .ADDR_W    (ADDR_W)
  ) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .role      (role),
    .addr      (line_addr),
    .sample    (bus.conv2_out_2),
    .max_value (bus.max_value_2)
  );

  pool2_channel #(
    .WIDTH     (WIDTH),
    .DATA_BITS (DATA_BITS),
    .ADDR_W    (ADDR_W)
  ) u_ch3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .role      (role),
    .addr      (line_addr),
    .sample    (bus.conv2_out_3),
    .max_value (bus.max_value_3)
  );

endmodule

// File: tb/tb_maxpool_relu2.sv
// Self-checking bench for maxpool_relu2.
//
// Purpose:
//   Drives pixel frames through the interface. A reference model keeps the
//   whole input image and pushes the 2x2 maximum into a scoreboard queue
//   when the fourth pixel of each window is driven. A negedge monitor pops
//   and compares every valid output, and checks that outputs hold (or are
//   zero after reset) when no output is due.
//
// Ports: none (top-level bench).
//
// Configuration: honours MAXPOOL2_RELU_EN in the reference model.
module tb_maxpool_relu2;
  import cnn_pkg::*;

  localparam int W  = CONV2_WIDTH;
  localparam int H  = CONV2_HEIGHT;
  localparam int DB = CNN_DATA_BITS;

  typedef logic signed [DB-1:0] sample_t;

  typedef struct {
    sample_t v1;
    sample_t v2;
    sample_t v3;
    logic    fd;
    int      due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_seen = 1'b1;

  always #5 clk = ~clk;

  maxpool_relu2_if #(.DATA_BITS(DB)) bus ();

  maxpool_relu2 #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .DATA_BITS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t    sb_q[$];
  exp_t    cur;
  sample_t img [3][H][W];
  sample_t last_v1 = '0;
  sample_t last_v2 = '0;
  sample_t last_v3 = '0;
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      fd_seen = 0;
  int      fd_expected = 0;
  int      mr = 0;
  int      mc = 0;
  logic    ramp_mode = 1'b0;
  int      ramp_idx = 0;

  // Cycle counter and a registered view of reset, so the monitor knows
  // which edge applied the reset.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic sample_t act(input sample_t s);
`ifdef MAXPOOL2_RELU_EN
    return (s < 0) ? sample_t'(0) : s;
`else
    return s;
`endif
  endfunction

  function automatic sample_t max4(input int ch, input int r, input int c);
    sample_t m = img[ch][r-1][c-1];
    if (img[ch][r-1][c] > m) m = img[ch][r-1][c];
    if (img[ch][r][c-1] > m) m = img[ch][r][c-1];
    if (img[ch][r][c] > m)   m = img[ch][r][c];
    return m;
  endfunction

  // Drive one pixel for one cycle, update the model, then idle for gap
  // cycles. The caller is always 1 time unit after a rising edge.
  task automatic apply_stimulus(input sample_t a, input sample_t b,
                                input sample_t c, input int gap);
    exp_t e;
    bus.valid_in    = 1'b1;
    bus.conv2_out_1 = a;
    bus.conv2_out_2 = b;
    bus.conv2_out_3 = c;
    img[0][mr][mc]  = act(a);
    img[1][mr][mc]  = act(b);
    img[2][mr][mc]  = act(c);
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      e.v1  = max4(0, mr, mc);
      e.v2  = max4(1, mr, mc);
      e.v3  = max4(2, mr, mc);
      e.fd  = (mr == H - 1) && (mc == W - 1);
      e.due = cyc + 1;
      if (e.fd) fd_expected++;
      sb_q.push_back(e);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pattern 0 is a ramp, 1 is all negative, 2 is random, and 3 is a single
  // hot pixel at (6,6).
  task automatic send_frame(input int pattern, input int gap, input int npix);
    sample_t a, b, c;
    for (int i = 0; i < npix; i++) begin
      int r = i / W;
      int col = i % W;
      case (pattern)
        0: begin
          a = sample_t'(r * W + col);
          b = sample_t'(-(r * W + col));
          c = sample_t'((r * W + col) * 3);
        end
        1: begin
          a = ((r == 1) && (col == 1)) ? sample_t'(-2) : sample_t'(-5);
          b = a;
          c = a;
        end
        2: begin
          a = sample_t'($urandom);
          b = sample_t'($urandom);
          c = sample_t'($urandom);
        end
        default: begin
          a = ((r == 6) && (col == 6)) ? sample_t'(100)   : sample_t'(0);
          b = ((r == 6) && (col == 6)) ? sample_t'(-100)  : sample_t'(0);
          c = ((r == 6) && (col == 6)) ? sample_t'(12'h7FF) : sample_t'(0);
        end
      endcase
      apply_stimulus(a, b, c, gap);
    end
  endtask

  // Output monitor, sampling mid-cycle. After a reset edge it expects zeros.
  // On a valid output it compares against the scoreboard head. Otherwise it
  // expects the last result to hold.
  always @(negedge clk) begin
    if (bus.frame_done) begin
      fd_seen++;
      check_output("fd_with_valid", bus.valid_out, 1);
    end
    if (rst_seen) begin
      last_v1 = '0;
      last_v2 = '0;
      last_v3 = '0;
      check_output("rst_valid", bus.valid_out, 0);
      check_output("rst_fd", bus.frame_done, 0);
      check_output("rst_v1", bus.max_value_1, 0);
      check_output("rst_v2", bus.max_value_2, 0);
      check_output("rst_v3", bus.max_value_3, 0);
    end else if (bus.valid_out) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_valid", bus.valid_out, 0);
      end else begin
        cur = sb_q.pop_front();
        check_output("v1", bus.max_value_1, cur.v1);
        check_output("v2", bus.max_value_2, cur.v2);
        check_output("v3", bus.max_value_3, cur.v3);
        check_output("fd", bus.frame_done, cur.fd);
        check_output("latency", cyc, cur.due);
        last_v1 = cur.v1;
        last_v2 = cur.v2;
        last_v3 = cur.v3;
        if (ramp_mode) begin
          check_output("ramp_ch1", bus.max_value_1,
                       (2 * (ramp_idx / (W / 2)) + 1) * W + 2 * (ramp_idx % (W / 2)) + 1);
          ramp_idx = (ramp_idx + 1) % ((W / 2) * (H / 2));
        end
      end
    end else begin
      check_output("hold_v1", bus.max_value_1, last_v1);
      check_output("hold_v2", bus.max_value_2, last_v2);
      check_output("hold_v3", bus.max_value_3, last_v3);
    end
  end

  initial begin
    bus.valid_in    = 1'b0;
    bus.conv2_out_1 = '0;
    bus.conv2_out_2 = '0;
    bus.conv2_out_3 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] ramp frame");
    ramp_mode = 1'b1;
    ramp_idx  = 0;
    send_frame(0, 0, W * H);
    repeat (3) begin @(posedge clk); #1; end
    ramp_mode = 1'b0;

    $display("[TB] negative frame");
    send_frame(1, 0, W * H);
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] gapped ramp frame");
    ramp_mode = 1'b1;
    ramp_idx  = 0;
    send_frame(0, 2, W * H);
    repeat (3) begin @(posedge clk); #1; end
    ramp_mode = 1'b0;

    $display("[TB] back-to-back frames");
    send_frame(2, 0, W * H);
    send_frame(0, 0, W * H);
    send_frame(2, 0, W * H);
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] mid-frame reset");
    send_frame(2, 0, 37);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("sb_empty_at_reset", sb_q.size(), 0);
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
    send_frame(2, 0, W * H);
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] channel independence");
    send_frame(3, 0, W * H);

    repeat (4) begin @(posedge clk); #1; end
    check_output("sb_drain", sb_q.size(), 0);
    check_output("frame_done_count", fd_seen, fd_expected);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
